// File: rtl/bram_wr_ctrl.sv
// -----------------------------------------------------------------------------
// bram_wr_ctrl
//
// Writes one cache line (LINE_W bits) into a bank of WAYS parallel BRAMs as two
// consecutive half-line beats, then flags the line valid in a per-line bitmap.
//
// A line request is accepted with a valid/ready handshake and held in a
// holding register. Beat 0 writes the low half at address {st,cl,0}, beat 1
// writes the high half at {st,cl,1}. A new line can be accepted during beat 1,
// which gives a sustained rate of one line every two cycles. The cycle after
// beat 1 a done pulse reports the line, and its valid bit becomes visible in
// that same cycle. Invalidate strobes clear valid bits at any time; when an
// invalidate and a done-set land on the same bit at the same edge, the set
// wins because the freshly written data is the newest.
//
// Ports
//   clk2x       in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   i_v / i_r   in/out  line write request valid / ready
//   i_st, i_cl  in   target stream and cache line of the request
//   i_d         in   line data (LINE_W bits)
//   o_we        out  BRAM slice write enable
//   o_wa        out  BRAM slice address {st, cl, beat}
//   o_wd        out  BRAM slice data (one half-line)
//   i_inv_v     in   invalidate strobe, always accepted
//   i_inv_st/cl in   invalidate target
//   o_done_v    out  one-cycle line-written pulse
//   o_done_st/cl out line just written
//   o_vld       out  per-line valid bitmap, bit index st*L1_NCL+cl
// -----------------------------------------------------------------------------
module bram_wr_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int WAYS       = 8,
  parameter int L1_NSTRMS  = 16,
  parameter int L1_NCL     = 16,
  localparam int ST_W       = $clog2(L1_NSTRMS),
  localparam int CL_W       = $clog2(L1_NCL),
  localparam int ADDR_WIDTH = ST_W + CL_W + 1,
  localparam int HALF_W     = WAYS * DATA_WIDTH,
  localparam int LINE_W     = 2 * HALF_W,
  localparam int NLINES     = L1_NSTRMS * L1_NCL
) (
  input  logic                  clk2x,
  input  logic                  reset,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [ST_W-1:0]       i_st,
  input  logic [CL_W-1:0]       i_cl,
  input  logic [LINE_W-1:0]     i_d,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_wa,
  output logic [HALF_W-1:0]     o_wd,
  input  logic                  i_inv_v,
  input  logic [ST_W-1:0]       i_inv_st,
  input  logic [CL_W-1:0]       i_inv_cl,
  output logic                  o_done_v,
  output logic [ST_W-1:0]       o_done_st,
  output logic [CL_W-1:0]       o_done_cl,
  output logic [NLINES-1:0]     o_vld
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              accept;
  logic              beat1;
  logic [ST_W-1:0]   h_st;
  logic [CL_W-1:0]   h_cl;
  logic [LINE_W-1:0] h_d;

  logic              done_q;
  logic [ST_W-1:0]   done_st_q;
  logic [CL_W-1:0]   done_cl_q;
  logic [NLINES-1:0] vld_q;

  // Field widths are powers of two, so the bitmap index is a plain concatenation.
  logic [ST_W+CL_W-1:0] wr_idx;
  logic [ST_W+CL_W-1:0] inv_idx;

  // Ready depends on state only; the holding register is free in IDLE and
  // again during beat 1, because beat 1 already reads its half at this edge.
  assign i_r     = (state == IDLE) || (state == B1);
  assign accept  = i_v && i_r && !reset;
  assign beat1   = (state == B1);
  assign wr_idx  = {h_st, h_cl};
  assign inv_idx = {i_inv_st, i_inv_cl};

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? B0 : IDLE;
      B0:      state_nxt = B1;
      B1:      state_nxt = accept ? B0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk2x) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the holding register carries no reset; it is only observed while
  // the FSM is in B0/B1, which reset leaves, so its stale content is harmless.
  always_ff @(posedge clk2x) begin
    if (accept) begin
      h_st <= i_st;
      h_cl <= i_cl;
      h_d  <= i_d;
    end
  end

  always_ff @(posedge clk2x) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= beat1;
  end

  always_ff @(posedge clk2x) begin
    if (beat1) begin
      done_st_q <= h_st;
      done_cl_q <= h_cl;
    end
  end

  // The set is written after the clear so that it wins on a same-bit collision.
  always_ff @(posedge clk2x) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      if (i_inv_v) vld_q[inv_idx] <= 1'b0;
      if (beat1)   vld_q[wr_idx]  <= 1'b1;
    end
  end

  // Write port. Address and data are only meaningful while o_we is high.
  // Reset silences the visible outputs immediately, not one edge later.
  assign o_we      = ((state == B0) || beat1) && !reset;
  assign o_wa      = {h_st, h_cl, beat1};
  assign o_wd      = beat1 ? h_d[LINE_W-1:HALF_W] : h_d[HALF_W-1:0];

  assign o_done_v  = done_q && !reset;
  assign o_done_st = done_st_q;
  assign o_done_cl = done_cl_q;
  assign o_vld     = reset ? '0 : vld_q;

endmodule

// File: tb/tb_bram_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_wr_ctrl
//
// Directed bench for bram_wr_ctrl at default parameters (64-bit ways, 8 ways,
// 16 streams x 16 lines): reset behaviour, single line, back-to-back lines,
// invalidate interactions, reset in mid-line, corner addressing, then a
// random phase checked against a cycle model, a BRAM model and a reference
// valid bitmap.
// -----------------------------------------------------------------------------
module tb_bram_wr_ctrl;

  logic           clk2x;
  logic           reset;
  logic           i_v;
  logic           i_r;
  logic [3:0]     i_st;
  logic [3:0]     i_cl;
  logic [1023:0]  i_d;
  logic           o_we;
  logic [8:0]     o_wa;
  logic [511:0]   o_wd;
  logic           i_inv_v;
  logic [3:0]     i_inv_st;
  logic [3:0]     i_inv_cl;
  logic           o_done_v;
  logic [3:0]     o_done_st;
  logic [3:0]     o_done_cl;
  logic [255:0]   o_vld;

  int checks = 0;
  int errors = 0;

  bram_wr_ctrl dut (
    .clk2x     (clk2x),
    .reset     (reset),
    .i_v       (i_v),
    .i_r       (i_r),
    .i_st      (i_st),
    .i_cl      (i_cl),
    .i_d       (i_d),
    .o_we      (o_we),
    .o_wa      (o_wa),
    .o_wd      (o_wd),
    .i_inv_v   (i_inv_v),
    .i_inv_st  (i_inv_st),
    .i_inv_cl  (i_inv_cl),
    .o_done_v  (o_done_v),
    .o_done_st (o_done_st),
    .o_done_cl (o_done_cl),
    .o_vld     (o_vld)
  );

  initial clk2x = 1'b0;
  always #5 clk2x = ~clk2x;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk2x);
    #1;
  endtask

  // Distinct 32-bit words: {seed, word index}.
  function automatic logic [1023:0] mk_line(input int seed);
    logic [1023:0] l;
    for (int w = 0; w < 32; w++) l[w*32 +: 32] = {seed[15:0], w[15:0]};
    return l;
  endfunction

  // Random-phase model state.
  int            ph;
  logic [3:0]    hst, hcl;
  logic [1023:0] hd;
  logic [255:0]  rvld;
  logic          rdone;
  logic [3:0]    rdst, rdcl;
  logic          exp_ir, acc;
  logic [8:0]    exp_wa;
  logic [511:0]  bram [512];
  logic [511:0]  rmem [512];
  bit            rwr  [512];
  logic [1023:0] p;

  initial begin
    reset    = 1'b1;
    i_v      = 1'b1;          // request during reset must be ignored
    i_st     = 4'd9;
    i_cl     = 4'd9;
    i_d      = mk_line(99);
    i_inv_v  = 1'b0;
    i_inv_st = 4'd0;
    i_inv_cl = 4'd0;

    // ---------------- reset ----------------
    repeat (3) tick();
    check("rst_we",   o_we,     1'b0);
    check("rst_done", o_done_v, 1'b0);
    check("rst_vld",  o_vld,    256'd0);
    reset = 1'b0;
    i_v   = 1'b0;
    tick();
    check("rst_ir_after", i_r,  1'b1);
    check("rst_no_acc_we", o_we, 1'b0);
    tick();
    check("rst_no_acc_we2", o_we,   1'b0);
    check("rst_no_done",    o_done_v, 1'b0);

    // ---------------- single line st=3 cl=5 ----------------
    p    = mk_line(1);
    i_v  = 1'b1;
    i_st = 4'd3;
    i_cl = 4'd5;
    i_d  = p;
    check("s_ir_idle", i_r, 1'b1);
    tick();                                  // beat 0
    i_v = 1'b0;
    check("s_b0_we", o_we, 1'b1);
    check("s_b0_wa", o_wa, {4'd3, 4'd5, 1'b0});
    check("s_b0_wd", o_wd, p[511:0]);
    check("s_b0_ir", i_r,  1'b0);
    tick();                                  // beat 1
    check("s_b1_we",   o_we, 1'b1);
    check("s_b1_wa",   o_wa, {4'd3, 4'd5, 1'b1});
    check("s_b1_wd",   o_wd, p[1023:512]);
    check("s_b1_ir",   i_r,  1'b1);
    check("s_b1_done", o_done_v, 1'b0);
    check("s_b1_vld",  o_vld[53], 1'b0);
    tick();                                  // done cycle
    check("s_done_v",  o_done_v,  1'b1);
    check("s_done_st", o_done_st, 4'd3);
    check("s_done_cl", o_done_cl, 4'd5);
    check("s_vld",     o_vld,     {202'd0, 1'b1, 53'd0});
    check("s_we_idle", o_we,      1'b0);
    tick();
    check("s_done_1cyc", o_done_v, 1'b0);

    // ---------------- back-to-back: 4 lines st=1 cl=0..3 ----------------
    // Cycle c presents line (c+1)/2; accepts happen at c=0,2,4,6.
    for (int c = 0; c <= 10; c++) begin
      i_v  = (c <= 6);
      i_st = 4'd1;
      i_cl = 4'((c + 1) / 2);
      i_d  = mk_line(10 + (c + 1) / 2);
      check($sformatf("b2b_ir_c%0d", c), i_r, ((c % 2) == 0) || (c == 9));
      check($sformatf("b2b_we_c%0d", c), o_we, (c >= 1) && (c <= 8));
      if ((c >= 1) && (c <= 8)) begin
        p = mk_line(10 + (c - 1) / 2);
        check($sformatf("b2b_wa_c%0d", c), o_wa, {4'd1, 4'((c - 1) / 2), 1'((c - 1) % 2)});
        check($sformatf("b2b_wd_c%0d", c), o_wd, ((c - 1) % 2) ? p[1023:512] : p[511:0]);
      end
      check($sformatf("b2b_done_c%0d", c), o_done_v, (c == 3) || (c == 5) || (c == 7) || (c == 9));
      if (c == 3 || c == 5 || c == 7 || c == 9) begin
        check($sformatf("b2b_dst_c%0d", c), o_done_st, 4'd1);
        check($sformatf("b2b_dcl_c%0d", c), o_done_cl, 4'((c - 3) / 2));
      end
      tick();
    end
    i_v = 1'b0;
    check("b2b_vld", o_vld, {202'd0, 1'b1, 33'd0, 4'hF, 16'd0});

    // ---------------- invalidate ----------------
    i_v = 1'b1; i_st = 4'd0; i_cl = 4'd0; i_d = mk_line(20);
    tick(); i_v = 1'b0;
    tick(); tick();
    check("inv_pre_done", o_done_v, 1'b1);
    check("inv_pre_vld",  o_vld[0], 1'b1);
    tick();
    i_inv_v = 1'b1; i_inv_st = 4'd0; i_inv_cl = 4'd0;
    tick();
    i_inv_v = 1'b0;
    check("inv_cleared",   o_vld[0],  1'b0);
    check("inv_other_bit", o_vld[53], 1'b1);

    // invalidate colliding with the done-set of the same line: set wins
    i_v = 1'b1; i_st = 4'd0; i_cl = 4'd0; i_d = mk_line(21);
    tick(); i_v = 1'b0;                      // beat 0
    tick();                                  // beat 1
    i_inv_v = 1'b1; i_inv_st = 4'd0; i_inv_cl = 4'd0;
    tick();                                  // done cycle
    i_inv_v = 1'b0;
    check("coll_done", o_done_v, 1'b1);
    check("coll_vld",  o_vld[0], 1'b1);
    tick();
    check("coll_vld_hold", o_vld[0], 1'b1);

    // rewrite an already valid line: bit stays 1 throughout
    i_v = 1'b1; i_st = 4'd3; i_cl = 4'd5; i_d = mk_line(22);
    tick(); i_v = 1'b0;
    check("rew_vld_b0", o_vld[53], 1'b1);
    tick();
    check("rew_vld_b1", o_vld[53], 1'b1);
    tick();
    check("rew_vld_done", o_vld[53], 1'b1);
    check("rew_done",     o_done_v,  1'b1);

    // invalidate a line while it is in flight: cleared now, set again at done
    i_v = 1'b1; i_st = 4'd3; i_cl = 4'd5; i_d = mk_line(23);
    tick(); i_v = 1'b0;                      // beat 0
    i_inv_v = 1'b1; i_inv_st = 4'd3; i_inv_cl = 4'd5;
    tick();                                  // beat 1
    i_inv_v = 1'b0;
    check("fly_vld_cleared", o_vld[53], 1'b0);
    tick();
    check("fly_done",    o_done_v,  1'b1);
    check("fly_vld_set", o_vld[53], 1'b1);

    // ---------------- reset in mid-line ----------------
    i_v = 1'b1; i_st = 4'd7; i_cl = 4'd7; i_d = mk_line(30);
    tick(); i_v = 1'b0;                      // beat 0
    check("mid_b0_we", o_we, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_we_now", o_we, 1'b0);
    tick();
    check("mid_rst_we",   o_we,     1'b0);
    check("mid_rst_done", o_done_v, 1'b0);
    check("mid_rst_vld",  o_vld,    256'd0);
    reset = 1'b0;
    tick();
    check("mid_no_b1",   o_we,     1'b0);
    check("mid_no_done", o_done_v, 1'b0);
    check("mid_idle_ir", i_r,      1'b1);
    tick();
    check("mid_no_done2", o_done_v, 1'b0);
    check("mid_vld",      o_vld,    256'd0);

    // ---------------- corner address st=15 cl=15 ----------------
    p = mk_line(40);
    i_v = 1'b1; i_st = 4'd15; i_cl = 4'd15; i_d = p;
    tick(); i_v = 1'b0;
    check("bnd_wa0", o_wa, 9'h1FE);
    check("bnd_wd0", o_wd, p[511:0]);
    tick();
    check("bnd_wa1", o_wa, 9'h1FF);
    check("bnd_wd1", o_wd, p[1023:512]);
    tick();
    check("bnd_done_st", o_done_st, 4'd15);
    check("bnd_done_cl", o_done_cl, 4'd15);
    check("bnd_vld",     o_vld,     {1'b1, 255'd0});
    tick();

    // ---------------- random traffic with scoreboard ----------------
    ph    = 0;
    rvld  = {1'b1, 255'd0};
    rdone = 1'b0;
    rdst  = 4'd0;
    rdcl  = 4'd0;
    hst   = 4'd0;
    hcl   = 4'd0;
    hd    = '0;
    for (int a = 0; a < 512; a++) rwr[a] = 1'b0;

    for (int k = 0; k < 304; k++) begin
      i_v      = (k < 300) && ($urandom_range(0, 2) != 0);
      i_st     = 4'($urandom_range(0, 1));
      i_cl     = 4'($urandom_range(0, 3));
      i_d      = mk_line(1000 + k);
      i_inv_v  = (k < 300) && ($urandom_range(0, 3) == 0);
      i_inv_st = 4'($urandom_range(0, 1));
      i_inv_cl = 4'($urandom_range(0, 3));
      #1;
      exp_ir = (ph != 1);
      check("rnd_ir", i_r, exp_ir);
      check("rnd_we", o_we, ph != 0);
      if (ph != 0) begin
        exp_wa = {hst, hcl, ph == 2};
        check("rnd_wa", o_wa, exp_wa);
        rmem[exp_wa] = (ph == 2) ? hd[1023:512] : hd[511:0];
        rwr[exp_wa]  = 1'b1;
      end
      if (o_we) bram[o_wa] = o_wd;
      check("rnd_vld",  o_vld,    rvld);
      check("rnd_done", o_done_v, rdone);
      if (rdone) begin
        check("rnd_dst", o_done_st, rdst);
        check("rnd_dcl", o_done_cl, rdcl);
      end
      // advance the reference by one edge
      acc   = i_v && exp_ir;
      rdone = (ph == 2);
      rdst  = hst;
      rdcl  = hcl;
      if (i_inv_v) rvld[{i_inv_st, i_inv_cl}] = 1'b0;
      if (ph == 2) rvld[{hst, hcl}] = 1'b1;
      ph = (ph == 1) ? 2 : (acc ? 1 : 0);
      if (acc) begin
        hst = i_st;
        hcl = i_cl;
        hd  = i_d;
      end
      @(posedge clk2x);
      #1;
    end

    for (int a = 0; a < 512; a++) begin
      if (rwr[a]) check($sformatf("rnd_bram_%0h", a), bram[a], rmem[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
